// File: rtl/serial_mac_pkg.sv
// Shared types, default sizes and sizing helper for the serial MAC engine.
package serial_mac_pkg;

   localparam int unsigned DEF_OP_W  = 8;
   localparam int unsigned DEF_ACC_W = 20;

   typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, UNLOAD} state_t;

   // Bits needed for a counter running 0..n-1.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
   endfunction

endpackage

// File: rtl/serial_mac_if.sv
// Serial operand/result handshake bundle between the pin-limited top and the MAC engine.
interface serial_mac_if;
   logic start;
   logic clear;
   logic a_ser;
   logic b_ser;
   logic in_valid;
   logic in_ready;
   logic out_bit;
   logic out_valid;
   logic out_ready;
   logic out_last;
   logic carry_out;
   logic busy;
   logic done;

   modport master (
      output start, clear, a_ser, b_ser, in_valid, out_ready,
      input  in_ready, out_bit, out_valid, out_last, carry_out, busy, done
   );

   modport slave (
      input  start, clear, a_ser, b_ser, in_valid, out_ready,
      output in_ready, out_bit, out_valid, out_last, carry_out, busy, done
   );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Unsigned sequential shift-add multiplier: one partial product per cycle, OP_W cycles after start.
module seq_shift_add_mult
   import serial_mac_pkg::*;
#(
   parameter int unsigned OP_W = DEF_OP_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic [2*OP_W-1:0] product,
   output logic              done_c
);

   localparam int unsigned PROD_W = 2 * OP_W;
   localparam int unsigned MC_W   = cnt_w(OP_W);

   logic [PROD_W-1:0] mcand_q;
   logic [PROD_W-1:0] prod_q;
   logic [OP_W-1:0]   mplier_q;
   logic [MC_W-1:0]   cnt_q;
   logic              run_q;

   // High during the cycle whose edge adds the final partial product.
   assign done_c  = run_q && (cnt_q == MC_W'(OP_W - 1));
   assign product = prod_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else if (start) begin
         mcand_q  <= PROD_W'(a);
         prod_q   <= '0;
         mplier_q <= b;
         cnt_q    <= '0;
         run_q    <= 1'b1;
      end else if (run_q) begin
         if (mplier_q[0]) begin
            prod_q <= prod_q + mcand_q;
         end
         mcand_q  <= {mcand_q[PROD_W-2:0], 1'b0};
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         if (done_c) begin
            run_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/serial_mac_engine.sv
// Bit-serial multiply-accumulate engine: serial operands in, shift-add multiply, persistent
// accumulator, serial result out. Define SERIAL_MAC_SAT_EN for saturating accumulation.
module serial_mac_engine
   import serial_mac_pkg::*;
#(
   parameter int unsigned OP_W  = DEF_OP_W,
   parameter int unsigned ACC_W = DEF_ACC_W
) (
   input  logic       clock,
   input  logic       reset_n,
   serial_mac_if.slave bus
);

   localparam int unsigned CNT_W  = cnt_w(ACC_W);
   localparam int unsigned SUM_W  = ACC_W + 1;
   localparam int unsigned PROD_W = 2 * OP_W;

   if (OP_W < 2) begin : g_bad_op_w
      $error("serial_mac_engine: OP_W must be at least 2");
   end
   if (ACC_W < 2 * OP_W) begin : g_bad_acc_w
      $error("serial_mac_engine: ACC_W must be at least 2*OP_W");
   end

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [OP_W-2:0]   a_q, b_q;
   logic [OP_W-1:0]   a_nxt, b_nxt;
   logic [ACC_W-1:0]  acc_q, shadow_q, acc_new;
   logic [SUM_W-1:0]  sum;
   logic [PROD_W-1:0] product;
   logic              carry_q;
   logic              in_ready_q, out_valid_q, out_last_q, busy_q, done_q;
   logic              in_ready_d, out_valid_d, out_last_d, busy_d, done_d;
   logic              accept, xfer, load_last, unload_last, mult_done_c;

   assign accept      = (state_q == LOAD) && bus.in_valid;
   assign xfer        = (state_q == UNLOAD) && bus.out_ready;
   assign load_last   = accept && (cnt_q == CNT_W'(OP_W - 1));
   assign unload_last = xfer && (cnt_q == CNT_W'(ACC_W - 1));
   assign a_nxt       = {a_q, bus.a_ser};
   assign b_nxt       = {b_q, bus.b_ser};

   // Multiplier is launched with the final operand bit so MUL lasts exactly OP_W cycles.
   seq_shift_add_mult #(.OP_W(OP_W)) u_mult (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (load_last),
      .a       (a_nxt),
      .b       (b_nxt),
      .product (product),
      .done_c  (mult_done_c)
   );

   assign sum = {1'b0, acc_q} + SUM_W'(product);
`ifdef SERIAL_MAC_SAT_EN
   assign acc_new = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
   assign acc_new = sum[ACC_W-1:0];
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next state and shared bit counter (operand bits in LOAD, result bits in UNLOAD).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         LOAD: begin
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               if (load_last) begin
                  state_d = MUL;
                  cnt_d   = '0;
               end
            end
         end
         MUL: begin
            if (mult_done_c) begin
               state_d = ACC;
            end
         end
         ACC: begin
            state_d = UNLOAD;
            cnt_d   = '0;
         end
         UNLOAD: begin
            if (xfer) begin
               cnt_d = cnt_q + 1'b1;
               if (unload_last) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decoded from the next state so they register in step with it.
   always_comb begin
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      in_ready_d  = (state_d == LOAD);
      out_valid_d = (state_d == UNLOAD);
      out_last_d  = (state_d == UNLOAD) && (cnt_d == CNT_W'(ACC_W - 1));
      busy_d      = (state_d != IDLE);
      done_d      = unload_last;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         shadow_q <= '0;
      end else begin
         if (accept) begin
            a_q <= a_nxt[OP_W-2:0];
            b_q <= b_nxt[OP_W-2:0];
         end
         if ((state_q == IDLE) && bus.clear) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
         end
         // Shadow decouples the streamed result from the live accumulator.
         if (state_q == ACC) begin
            acc_q    <= acc_new;
            carry_q  <= carry_q | sum[ACC_W];
            shadow_q <= acc_new;
         end else if (xfer) begin
            shadow_q <= {shadow_q[ACC_W-2:0], 1'b0};
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_bit   = shadow_q[ACC_W-1];
   assign bus.carry_out = carry_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_serial_mac_engine.sv
// Randomised self-checking bench for serial_mac_engine against an arithmetic accumulator model.
module tb_serial_mac_engine;

   localparam int OP_W  = 8;
   localparam int ACC_W = 20;
   localparam int NOSTALL_CYC = 2 * OP_W + 1 + ACC_W;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   serial_mac_if bus();

   serial_mac_engine #(.OP_W(OP_W), .ACC_W(ACC_W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int passed = 0;
   int total  = 0;

   longint unsigned acc_m;
   bit              carry_m;

   function automatic void model_clear();
      acc_m   = 0;
      carry_m = 1'b0;
   endfunction

   function automatic void model_mac(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
      longint unsigned modv = 64'd1 << ACC_W;
      longint unsigned s    = acc_m + 64'(a) * 64'(b);
      if (s >= modv) begin
         carry_m = 1'b1;
`ifdef SERIAL_MAC_SAT_EN
         acc_m = modv - 1;
`else
         acc_m = s % modv;
`endif
      end else begin
         acc_m = s;
      end
   endfunction

   // One complete MAC: start, stream operands, wait, collect the serial result.
   task automatic run_mac(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                          input bit with_clear, input bit gaps, input bit poke,
                          input int stall_pos, input int stall_len,
                          output logic [ACC_W-1:0] res, output int cycles,
                          output int gap_cnt, output bit proto_ok, output bit stable_ok);
      int  i;
      int  n;
      logic b0;
      proto_ok  = 1'b1;
      stable_ok = 1'b1;
      gap_cnt   = 0;
      res       = '0;
      @(negedge clock);
      bus.start = 1'b1;
      bus.clear = with_clear;
      if (with_clear) model_clear();
      @(negedge clock);
      bus.start = 1'b0;
      bus.clear = 1'b0;
      cycles    = 0;
      i = 0;
      n = 0;
      while (i < OP_W && n < 200) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            gap_cnt++;
         end else begin
            bus.in_valid = 1'b1;
            bus.a_ser    = a[OP_W-1-i];
            bus.b_ser    = b[OP_W-1-i];
            if (bus.in_ready !== 1'b1) proto_ok = 1'b0;
            i++;
         end
         @(negedge clock);
         cycles++;
         n++;
      end
      bus.in_valid = 1'b0;
      if (i < OP_W) proto_ok = 1'b0;
      model_mac(a, b);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 100) begin
         if (poke) bus.start = 1'b1;
         @(negedge clock);
         cycles++;
         n++;
      end
      bus.start = 1'b0;
      if (n >= 100) proto_ok = 1'b0;
      for (int k = 0; k < ACC_W; k++) begin
         if (k == stall_pos) begin
            for (int s = 0; s < stall_len; s++) begin
               bus.out_ready = 1'b0;
               b0 = bus.out_bit;
               @(negedge clock);
               cycles++;
               if (bus.out_bit !== b0 || bus.out_valid !== 1'b1) stable_ok = 1'b0;
            end
         end
         if (poke) bus.clear = 1'b1;
         bus.out_ready = 1'b1;
         if (bus.out_valid !== 1'b1) proto_ok = 1'b0;
         res[ACC_W-1-k] = bus.out_bit;
         if (bus.out_last !== (k == ACC_W - 1)) proto_ok = 1'b0;
         @(negedge clock);
         cycles++;
      end
      bus.out_ready = 1'b0;
      bus.clear     = 1'b0;
      if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) proto_ok = 1'b0;
      @(negedge clock);
      if (bus.done !== 1'b0) proto_ok = 1'b0;
   endtask

   task automatic test_reset();
      logic [6:0] obs;
      bus.start = 0; bus.clear = 0; bus.a_ser = 0; bus.b_ser = 0;
      bus.in_valid = 0; bus.out_ready = 0;
      reset_n = 1'b0;
      model_clear();
      repeat (3) @(negedge clock);
      obs = {bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.carry_out, bus.out_bit};
      total++;
      if (obs !== 7'b0) $display("FAIL reset_outputs: got %b expected 0000000", obs);
      else passed++;
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      total++;
      if (bus.busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", bus.busy);
      else passed++;
   endtask

   task automatic test_basic();
      logic [ACC_W-1:0] res;
      int cyc, gc;
      bit pok, sok;
      run_mac(8'd3, 8'd5, 1'b1, 1'b0, 1'b0, -1, 0, res, cyc, gc, pok, sok);
      total++;
      if (res !== ACC_W'(acc_m)) $display("FAIL basic_result: got %0d expected %0d", res, acc_m);
      else passed++;
      total++;
      if (pok !== 1'b1) $display("FAIL basic_protocol: got %b expected 1", pok);
      else passed++;
      total++;
      if (bus.carry_out !== carry_m) $display("FAIL basic_carry: got %b expected %b", bus.carry_out, carry_m);
      else passed++;
      total++;
      if (cyc != NOSTALL_CYC) $display("FAIL basic_cycles: got %0d expected %0d", cyc, NOSTALL_CYC);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [ACC_W-1:0] res;
      int cyc, gc;
      bit pok, sok;
      for (int r = 0; r < 2; r++) begin
         run_mac(8'd255, 8'd255, (r == 0), 1'b0, 1'b0, -1, 0, res, cyc, gc, pok, sok);
         total++;
         if (res !== ACC_W'(acc_m) || pok !== 1'b1)
            $display("FAIL b2b_result_%0d: got %0d/%b expected %0d/1", r, res, pok, acc_m);
         else passed++;
      end
   endtask

   task automatic test_overflow();
      logic [ACC_W-1:0] res;
      int cyc, gc;
      bit pok, sok;
      for (int r = 0; r < 17; r++) begin
         run_mac(8'd255, 8'd255, (r == 0), 1'b0, 1'b0, -1, 0, res, cyc, gc, pok, sok);
         total++;
         if (res !== ACC_W'(acc_m)) $display("FAIL ovf_result_%0d: got %0d expected %0d", r, res, acc_m);
         else passed++;
      end
      total++;
      if (bus.carry_out !== carry_m || carry_m !== 1'b1)
         $display("FAIL ovf_carry: got %b expected 1", bus.carry_out);
      else passed++;
      @(negedge clock);
      bus.clear = 1'b1;
      model_clear();
      @(negedge clock);
      bus.clear = 1'b0;
      @(negedge clock);
      total++;
      if (bus.carry_out !== 1'b0) $display("FAIL ovf_clear_carry: got %b expected 0", bus.carry_out);
      else passed++;
      run_mac(8'd1, 8'd1, 1'b0, 1'b0, 1'b0, -1, 0, res, cyc, gc, pok, sok);
      total++;
      if (res !== ACC_W'(acc_m)) $display("FAIL ovf_after_clear: got %0d expected %0d", res, acc_m);
      else passed++;
   endtask

   task automatic test_stalls();
      logic [ACC_W-1:0] res;
      int cyc, gc;
      bit pok, sok;
      run_mac(8'hA5, 8'h3C, 1'b1, 1'b1, 1'b0, 7, 5, res, cyc, gc, pok, sok);
      total++;
      if (res !== ACC_W'(acc_m)) $display("FAIL stall_result: got %0d expected %0d", res, acc_m);
      else passed++;
      total++;
      if (sok !== 1'b1 || pok !== 1'b1) $display("FAIL stall_stable: got %b/%b expected 1/1", sok, pok);
      else passed++;
      total++;
      if (cyc != NOSTALL_CYC + gc + 5)
         $display("FAIL stall_cycles: got %0d expected %0d", cyc, NOSTALL_CYC + gc + 5);
      else passed++;
   endtask

   task automatic test_reset_abort();
      logic [ACC_W-1:0] res;
      logic [6:0] obs;
      int cyc, gc, n;
      bit pok, sok;
      @(negedge clock); bus.start = 1'b1;
      @(negedge clock); bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1; bus.a_ser = 1'($urandom); bus.b_ser = 1'($urandom);
         @(negedge clock);
      end
      bus.in_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      obs = {bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.carry_out, bus.out_bit};
      total++;
      if (obs !== 7'b0) $display("FAIL abort_load: got %b expected 0000000", obs);
      else passed++;
      @(negedge clock); reset_n = 1'b1; model_clear();
      @(negedge clock); bus.start = 1'b1;
      @(negedge clock); bus.start = 1'b0;
      for (int i = 0; i < OP_W; i++) begin
         bus.in_valid = 1'b1; bus.a_ser = 1'b1; bus.b_ser = 1'b1;
         @(negedge clock);
      end
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 100) begin @(negedge clock); n++; end
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clock);
      bus.out_ready = 1'b0;
      reset_n = 1'b0;
      #1;
      obs = {bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.carry_out, bus.out_bit};
      total++;
      if (obs !== 7'b0 || n >= 100) $display("FAIL abort_unload: got %b (wait %0d) expected 0000000", obs, n);
      else passed++;
      @(negedge clock); reset_n = 1'b1; model_clear();
      run_mac(8'd1, 8'd1, 1'b0, 1'b0, 1'b0, -1, 0, res, cyc, gc, pok, sok);
      total++;
      if (res !== ACC_W'(acc_m) || pok !== 1'b1)
         $display("FAIL abort_next_op: got %0d/%b expected %0d/1", res, pok, acc_m);
      else passed++;
   endtask

   task automatic test_ignored_ctrl();
      logic [ACC_W-1:0] res;
      int cyc, gc;
      bit pok, sok;
      run_mac(OP_W'($urandom), OP_W'($urandom), 1'b0, 1'b0, 1'b1, -1, 0, res, cyc, gc, pok, sok);
      total++;
      if (res !== ACC_W'(acc_m) || pok !== 1'b1)
         $display("FAIL ignore_poke_op: got %0d/%b expected %0d/1", res, pok, acc_m);
      else passed++;
      run_mac(OP_W'($urandom), OP_W'($urandom), 1'b0, 1'b0, 1'b0, -1, 0, res, cyc, gc, pok, sok);
      total++;
      if (res !== ACC_W'(acc_m)) $display("FAIL ignore_clear_kept: got %0d expected %0d", res, acc_m);
      else passed++;
      run_mac(8'd2, 8'd7, 1'b1, 1'b0, 1'b0, -1, 0, res, cyc, gc, pok, sok);
      total++;
      if (res !== ACC_W'(acc_m)) $display("FAIL clear_start_same: got %0d expected %0d", res, acc_m);
      else passed++;
   endtask

   task automatic test_random();
      logic [ACC_W-1:0] res;
      int cyc, gc, len;
      bit pok, sok;
      for (int r = 0; r < 8; r++) begin
         len = $urandom_range(0, 3);
         run_mac(OP_W'($urandom), OP_W'($urandom), ($urandom_range(0, 3) == 0),
                 1'($urandom), 1'b0, $urandom_range(0, ACC_W - 1), len,
                 res, cyc, gc, pok, sok);
         total++;
         if (res !== ACC_W'(acc_m) || bus.carry_out !== carry_m || pok !== 1'b1 || sok !== 1'b1)
            $display("FAIL random_%0d: got %0d c%b p%b s%b expected %0d c%b p1 s1",
                     r, res, bus.carry_out, pok, sok, acc_m, carry_m);
         else passed++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_overflow();
      test_stalls();
      test_reset_abort();
      test_ignored_ctrl();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/serial_mac_engine.md
Name: serial_mac_engine

Overview:
Parametrised serial-I/O multiply-accumulate engine, the successor to the current fixed 8x8/20-bit chip-level MAC. Operands A and B arrive bit-serially on two pins, are multiplied by an internal sequential shift-add multiplier, and the product is added into a persistent accumulator. The accumulator is then streamed out bit-serially. It sits directly behind the pin-limited io_in/io_out top level, with valid/ready handshakes on both serial streams.

Parameters:
OP_W, 8, operand width in bits (>=2)
ACC_W, 20, accumulator width in bits; elaboration error if ACC_W < 2*OP_W

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  begin one MAC operation; sampled in IDLE only
clear  input  1  zero the accumulator and carry; acted on in IDLE only
a_ser  input  1  serial operand A bit, MSB first
b_ser  input  1  serial operand B bit, MSB first
in_valid  input  1  a_ser/b_ser carry a valid bit this cycle
in_ready  output  1  engine accepts a bit pair this cycle (LOAD state)
out_bit  output  1  serial accumulator bit, MSB first
out_valid  output  1  out_bit valid (UNLOAD state)
out_ready  input  1  consumer takes out_bit this cycle
out_last  output  1  high with the final (LSB) output bit
carry_out  output  1  sticky accumulator overflow flag
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last output bit transfers

Behaviour:
- Reset (async assert, sync deassert): state=IDLE. Accumulator, carry_out, operand and product registers, bit counter all 0. in_ready, out_valid, out_last, busy and done are all 0.
- States: IDLE -> LOAD -> MUL -> ACC -> UNLOAD -> IDLE.
- IDLE: on clear=1, acc<=0 and carry_out<=0. On start=1, go to LOAD and zero the bit counter. If clear and start are both 1 in the same cycle, both act: the new MAC accumulates onto zero.
- LOAD: in_ready=1. Each cycle with in_valid=1, shift a_ser and b_ser into the A and B registers and increment the counter. After OP_W accepted pairs, go to MUL. in_valid gaps stall the state with no penalty.
- MUL: shift-add over exactly OP_W cycles, giving a 2*OP_W-bit unsigned product. Then go to ACC.
- ACC: one cycle. sum = acc + zero-extended product, computed at ACC_W+1 bits. acc<=sum[ACC_W-1:0]. carry_out |= sum[ACC_W]. Then go to UNLOAD.
- UNLOAD: out_valid=1 and out_bit=current MSB of a shadow copy of acc. The shadow shifts only on out_valid&&out_ready. out_last=1 on the ACC_W-th bit. After that bit transfers, done pulses for 1 cycle and the state returns to IDLE. out_ready low holds all outputs stable.
- Latency: from the last accepted input pair to first out_valid is OP_W+1 cycles. Full op with no stalls: OP_W + OP_W + 1 + ACC_W cycles after start.
- start and clear outside IDLE are ignored. The accumulator persists across ops until clear or reset.
- Reset mid-operation aborts immediately to the reset state. No partial result is emitted.
- Accumulator wrap is modulo 2^ACC_W by default. carry_out stays set until clear or reset.

Optional Feature:
SERIAL_MAC_SAT_EN
- Defined: on overflow, acc saturates to all-ones (2^ACC_W-1) and carry_out is still set. Once saturated, acc stays at all-ones until clear.
- Undefined: modulo wrap as above.

Decomposition:
- Package serial_mac_pkg: state enum type (IDLE, LOAD, MUL, ACC, UNLOAD); default OP_W/ACC_W localparams; counter-width helper function ($clog2-based).
- One sub-module: seq_shift_add_mult (OP_W parameter; start/operands in, OP_W-cycle latency, 2*OP_W product plus done out). The FSM, serializers and accumulator stay in serial_mac_engine.

Test Plan:
1. OP_W=8, ACC_W=20. After reset: clear, start, A=3, B=5 streamed MSB first -> serial output 20'd15 (0x0000F). out_last on bit 20, done pulse, carry_out=0.
2. Two back-to-back MACs, A=255, B=255 each, no clear -> first output 65025, second 130050 (0x1FC02).
3. Seventeen MACs of 255x255 -> final output 56849 (1105425 mod 2^20), carry_out=1. With SERIAL_MAC_SAT_EN the output is 1048575, carry_out=1. A following clear returns acc to 0 and carry_out to 0.
4. Random in_valid gaps during LOAD and out_ready held low for 5 cycles mid-UNLOAD, A=0xA5, B=0x3C -> result 9900 is unchanged. out_bit stays stable while out_ready is low, and the total cycle count grows by exactly the stall cycles.
5. reset_n asserted during LOAD (after 4 bits) and again during UNLOAD -> outputs 0 immediately and state IDLE. The next op with A=1, B=1 outputs 1.
6. start asserted during MUL and clear asserted during UNLOAD -> both ignored and the result is unaffected. clear+start in the same IDLE cycle with A=2, B=7 -> output 14 regardless of the prior acc.
